// File: rtl/validity_sched.sv
`default_nettype none
// ============================================================================
// Module   : validity_sched
// Brief    : Round-robin scheduler sharing one fixed-latency validity/hash unit
//            between two requesters, with owner tracking and flush/drain.
//            Optional grant statistics: define VALIDITY_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module validity_sched #(
    parameter int W   = 3,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         unit_issue,
    output logic [W-1:0] unit_in0,
    output logic [W-1:0] unit_in1,
    input  logic         unit_result,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic         rsp_result,
    input  logic         flush,
    output logic         flush_done,
    output logic         busy
`ifdef VALIDITY_SCHED_STATS_EN
    ,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1
`endif
);

    // Counter must hold up to LAT+2 outstanding operations.
    localparam int c_CNT_W = $clog2(LAT + 3);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_last_grant;
    logic [c_CNT_W-1:0]   r_inflight;
    logic [LAT:0]         r_pipe_v;
    logic [LAT:0]         r_pipe_own;
    logic                 r_issue;
    logic [W-1:0]         r_in0;
    logic [W-1:0]         r_in1;
    logic                 r_rsp0;
    logic                 r_rsp1;
    logic                 r_rsp_res;
    logic                 r_flush_done;

    logic                 w_accept;
    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_hs;
    logic                 w_rsp;
    logic                 w_any_req;
    logic                 w_cnt_zero;

    assign w_accept   = (r_state != S_DRAIN) && !flush;
    assign w_grant0   = w_accept && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1   = w_accept && req1_valid && (!req0_valid || !r_last_grant);
    assign w_hs       = w_grant0 || w_grant1;
    assign w_rsp      = r_rsp0 || r_rsp1;
    assign w_any_req  = req0_valid || req1_valid;
    assign w_cnt_zero = (r_inflight == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (flush)          w_next = S_DRAIN;
                else if (w_any_req) w_next = S_RUN;
            end
            S_RUN: begin
                if (flush)                        w_next = S_DRAIN;
                else if (!w_any_req && w_cnt_zero) w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (w_cnt_zero) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_inflight   <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_flush_done <= (r_state == S_DRAIN) && w_cnt_zero;
            if (w_hs) r_last_grant <= w_grant1;
            case ({w_hs, w_rsp})
                2'b10:   r_inflight <= r_inflight + c_CNT_ONE;
                2'b01:   r_inflight <= r_inflight - c_CNT_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Stage k of the owner pipe lines up with cycle issue+k; stage LAT meets unit_result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue    <= 1'b0;
            r_in0      <= '0;
            r_in1      <= '0;
            r_pipe_v   <= '0;
            r_pipe_own <= '0;
            r_rsp0     <= 1'b0;
            r_rsp1     <= 1'b0;
            r_rsp_res  <= 1'b0;
        end else begin
            r_issue    <= w_hs;
            if (w_grant0) begin
                r_in0 <= req0_a;
                r_in1 <= req0_b;
            end else if (w_grant1) begin
                r_in0 <= req1_a;
                r_in1 <= req1_b;
            end
            r_pipe_v   <= {r_pipe_v[LAT-1:0], w_hs};
            r_pipe_own <= {r_pipe_own[LAT-1:0], w_grant1};
            r_rsp0     <= r_pipe_v[LAT] && !r_pipe_own[LAT];
            r_rsp1     <= r_pipe_v[LAT] && r_pipe_own[LAT];
            r_rsp_res  <= r_pipe_v[LAT] && unit_result;
        end
    end

`ifdef VALIDITY_SCHED_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (r_flush_done) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_grant0 && (r_cnt0 != 16'hFFFF)) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_grant1 && (r_cnt1 != 16'hFFFF)) r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign unit_issue = r_issue;
    assign unit_in0   = r_in0;
    assign unit_in1   = r_in1;
    assign rsp0_valid = r_rsp0;
    assign rsp1_valid = r_rsp1;
    assign rsp_result = r_rsp_res;
    assign flush_done = r_flush_done;
    assign busy       = (r_state != S_IDLE) || !w_cnt_zero;

endmodule
`default_nettype wire

// File: tb/tb_validity_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_validity_sched
// Brief    : Self-checking bench for validity_sched using a response-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_validity_sched;
    localparam int W   = 3;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         unit_issue, unit_result;
    logic [W-1:0] unit_in0, unit_in1;
    logic         rsp0_valid, rsp1_valid, rsp_result;
    logic         flush, flush_done, busy;
`ifdef VALIDITY_SCHED_STATS_EN
    logic [15:0]  grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    validity_sched #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .unit_issue(unit_issue), .unit_in0(unit_in0), .unit_in1(unit_in1),
        .unit_result(unit_result),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result),
        .flush(flush), .flush_done(flush_done), .busy(busy)
`ifdef VALIDITY_SCHED_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Model: each accepted request becomes a queued response due LAT+2 cycles later.
    typedef struct {
        int due;
        bit own;
        bit res;
    } rsp_t;

    rsp_t         q[$];
    bit           m_drain, m_run, m_fd, m_last, m_prev_hs;
    logic [W-1:0] m_prev_a, m_prev_b;
    int           cyc;
    bit           uv[64];
    bit           ur[64];
    bit           e_rdy0, e_rdy1, e_issue, e_rsp0, e_rsp1, e_res, e_fd, e_busy;
    logic [W-1:0] e_in0, e_in1;

    function automatic bit hashf(logic [W-1:0] a, logic [W-1:0] b);
        int x;
        x = int'(a) * 5 + int'(b) * 3 + 1;
        return x[1] ^ x[3];
    endfunction

    task automatic model_clear();
        q.delete();
        m_drain = 0; m_run = 0; m_fd = 0; m_last = 1; m_prev_hs = 0;
        m_prev_a = '0; m_prev_b = '0;
        for (int i = 0; i < 64; i++) begin
            uv[i] = 0;
            ur[i] = 0;
        end
    endtask

    task automatic sample();
        bit ok;
        @(negedge clk);
        ok      = !m_drain && !flush;
        e_rdy0  = ok && req0_valid && (!req1_valid || m_last);
        e_rdy1  = ok && req1_valid && (!req0_valid || !m_last);
        e_issue = m_prev_hs;
        e_in0   = m_prev_a;
        e_in1   = m_prev_b;
        e_rsp0  = 0; e_rsp1 = 0; e_res = 0;
        if (q.size() != 0 && q[0].due == cyc) begin
            e_rsp0 = !q[0].own;
            e_rsp1 = q[0].own;
            e_res  = q[0].res;
        end
        e_fd   = m_fd;
        e_busy = m_run || m_drain || (q.size() != 0);
    endtask

    task automatic advance();
        int   cnt0;
        bit   nfd;
        rsp_t e;
        cnt0 = q.size();
        nfd  = 0;
        if (unit_issue === 1'b1) begin
            uv[(cyc + LAT) % 64] = 1;
            ur[(cyc + LAT) % 64] = hashf(unit_in0, unit_in1);
        end
        uv[cyc % 64] = 0;
        if (q.size() != 0 && q[0].due == cyc) void'(q.pop_front());
        m_prev_hs = e_rdy0 || e_rdy1;
        if (e_rdy0) begin
            e.due = cyc + LAT + 2; e.own = 0; e.res = hashf(req0_a, req0_b);
            q.push_back(e);
            m_prev_a = req0_a; m_prev_b = req0_b; m_last = 0;
        end else if (e_rdy1) begin
            e.due = cyc + LAT + 2; e.own = 1; e.res = hashf(req1_a, req1_b);
            q.push_back(e);
            m_prev_a = req1_a; m_prev_b = req1_b; m_last = 1;
        end
        if (m_drain) begin
            if (cnt0 == 0) begin
                m_drain = 0; m_run = 0; nfd = 1;
            end
        end else if (flush) begin
            m_drain = 1; m_run = 0;
        end else if (!m_run) begin
            if (req0_valid || req1_valid) m_run = 1;
        end else if (!req0_valid && !req1_valid && cnt0 == 0) begin
            m_run = 0;
        end
        m_fd = nfd;
        @(posedge clk);
        #1;
        cyc++;
        unit_result = uv[cyc % 64] ? ur[cyc % 64] : 1'($urandom_range(0, 1));
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; flush = 0;
    endtask

    task automatic test_reset();
        sample();
        checks++;
        if ({unit_issue, unit_in0, unit_in1} !== '0) begin
            failures++;
            $display("FAIL reset_issue got=%b/%0d/%0d exp=0/0/0", unit_issue, unit_in0, unit_in1);
        end
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp_result} !== 3'b000) begin
            failures++;
            $display("FAIL reset_rsp got=%b%b%b exp=000", rsp0_valid, rsp1_valid, rsp_result);
        end
        checks++;
        if ({flush_done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_fd_busy got=%b%b exp=00", flush_done, busy);
        end
        advance();
    endtask

    task automatic test_contention();
        int g[$], in0s[$], owners[$];
        int first_grant, first_rsp;
        int exp_g[4]   = '{0, 1, 0, 1};
        int exp_in0[4] = '{5, 0, 5, 0};
        first_grant = -1; first_rsp = -1;
        for (int i = 0; i < 11; i++) begin
            req0_valid = (i < 4); req0_a = 3'd5; req0_b = 3'd1;
            req1_valid = (i < 4); req1_a = 3'd0; req1_b = 3'd7;
            sample();
            if (i < 4) begin
                g.push_back(req1_ready ? 1 : (req0_ready ? 0 : -1));
                if (first_grant < 0) first_grant = cyc;
            end
            if (unit_issue === 1'b1) in0s.push_back(int'(unit_in0));
            if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
                owners.push_back(rsp1_valid ? 1 : 0);
                if (first_rsp < 0) first_rsp = cyc;
            end
            checks++;
            if ({rsp0_valid, rsp1_valid, rsp_result} !== {e_rsp0, e_rsp1, e_res}) begin
                failures++;
                $display("FAIL contention_rsp cyc=%0d got=%b%b%b exp=%b%b%b", cyc,
                         rsp0_valid, rsp1_valid, rsp_result, e_rsp0, e_rsp1, e_res);
            end
            advance();
        end
        idle_inputs();
        checks++;
        if (g.size() != 4 || g[0] != exp_g[0] || g[1] != exp_g[1] || g[2] != exp_g[2] || g[3] != exp_g[3]) begin
            failures++;
            $display("FAIL contention_grants got=%p exp=0,1,0,1", g);
        end
        checks++;
        if (in0s.size() != 4 || in0s[0] != exp_in0[0] || in0s[1] != exp_in0[1] ||
            in0s[2] != exp_in0[2] || in0s[3] != exp_in0[3]) begin
            failures++;
            $display("FAIL contention_in0 got=%p exp=5,0,5,0", in0s);
        end
        checks++;
        if (owners.size() != 4 || owners[0] != 0 || owners[1] != 1 || owners[2] != 0 || owners[3] != 1) begin
            failures++;
            $display("FAIL contention_owners got=%p exp=0,1,0,1", owners);
        end
        checks++;
        if (first_rsp - first_grant != LAT + 2) begin
            failures++;
            $display("FAIL contention_latency got=%0d exp=%0d", first_rsp - first_grant, LAT + 2);
        end
    endtask

    task automatic test_single();
        int t_hs, t_rsp;
        t_rsp = -1;
        req0_valid = 1; req0_a = 3'd1; req0_b = 3'd1;
        sample();
        t_hs = cyc;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready got=%b%b exp=10", req0_ready, req1_ready);
        end
        advance();
        req0_valid = 0;
        for (int i = 0; i < 7; i++) begin
            sample();
            if (i == 0) begin
                checks++;
                if ({unit_issue, unit_in0, unit_in1} !== {1'b1, 3'd1, 3'd1}) begin
                    failures++;
                    $display("FAIL single_issue got=%b/%0d/%0d exp=1/1/1", unit_issue, unit_in0, unit_in1);
                end
            end
            if (rsp0_valid === 1'b1 && t_rsp < 0) begin
                t_rsp = cyc;
                checks++;
                if (rsp_result !== hashf(3'd1, 3'd1)) begin
                    failures++;
                    $display("FAIL single_result got=%b exp=%b", rsp_result, hashf(3'd1, 3'd1));
                end
            end
            advance();
        end
        checks++;
        if (t_rsp - t_hs != LAT + 2) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=%0d", t_rsp - t_hs, LAT + 2);
        end
        sample();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle_busy got=%b exp=0", busy);
        end
        advance();
    endtask

    task automatic test_truncate();
        int big;
        big = 67;
        req1_valid = 1; req1_a = big[W-1:0]; req1_b = 3'd2;
        sample();
        advance();
        req1_valid = 0;
        sample();
        checks++;
        if (unit_issue !== 1'b1 || unit_in0 !== 3'd3 || unit_in1 !== 3'd2) begin
            failures++;
            $display("FAIL truncate_in got=%b/%0d/%0d exp=1/3/2", unit_issue, unit_in0, unit_in1);
        end
        advance();
        for (int i = 0; i < 6; i++) begin
            sample();
            checks++;
            if ({rsp0_valid, rsp1_valid, rsp_result} !== {e_rsp0, e_rsp1, e_res}) begin
                failures++;
                $display("FAIL truncate_rsp got=%b%b%b exp=%b%b%b", rsp0_valid, rsp1_valid,
                         rsp_result, e_rsp0, e_rsp1, e_res);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        int nrsp, last_rsp, fd_cyc;
        bit busy_at_fd;
        nrsp = 0; last_rsp = -1; fd_cyc = -1; busy_at_fd = 1;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1; req0_a = W'($urandom_range(0, 7)); req0_b = W'($urandom_range(0, 7));
            sample();
            advance();
        end
        flush = 1; req1_valid = 1; req1_a = 3'd4; req1_b = 3'd4;
        sample();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            failures++;
            $display("FAIL flush_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        advance();
        flush = 0;
        for (int i = 0; i < 14; i++) begin
            req0_valid = (i < 2); req1_valid = (i < 2);
            sample();
            if (i < 2) begin
                checks++;
                if ({req0_ready, req1_ready} !== 2'b00) begin
                    failures++;
                    $display("FAIL drain_ready got=%b%b exp=00", req0_ready, req1_ready);
                end
            end
            checks++;
            if ({rsp0_valid, rsp1_valid, rsp_result} !== {e_rsp0, e_rsp1, e_res}) begin
                failures++;
                $display("FAIL drain_rsp cyc=%0d got=%b%b%b exp=%b%b%b", cyc, rsp0_valid,
                         rsp1_valid, rsp_result, e_rsp0, e_rsp1, e_res);
            end
            if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
                nrsp++;
                last_rsp = cyc;
            end
            if (flush_done === 1'b1 && fd_cyc < 0) begin
                fd_cyc = cyc;
                busy_at_fd = busy;
            end
            advance();
        end
        checks++;
        if (nrsp != 3) begin
            failures++;
            $display("FAIL drain_count got=%0d exp=3", nrsp);
        end
        checks++;
        if (fd_cyc != last_rsp + 2) begin
            failures++;
            $display("FAIL flush_done_time got=%0d exp=%0d", fd_cyc, last_rsp + 2);
        end
        checks++;
        if (busy_at_fd !== 1'b0) begin
            failures++;
            $display("FAIL drain_busy got=%b exp=0", busy_at_fd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 320; i++) begin
            if (i < 300) begin
                req0_valid = ($urandom_range(0, 9) < 7);
                req1_valid = ($urandom_range(0, 9) < 7);
                flush      = ($urandom_range(0, 14) == 0);
            end else begin
                idle_inputs();
            end
            req0_a = W'($urandom_range(0, 7)); req0_b = W'($urandom_range(0, 7));
            req1_a = W'($urandom_range(0, 7)); req1_b = W'($urandom_range(0, 7));
            sample();
            checks++;
            if ({req0_ready, req1_ready} !== {e_rdy0, e_rdy1}) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", cyc, req0_ready, req1_ready, e_rdy0, e_rdy1);
            end
            checks++;
            if ({unit_issue, unit_in0, unit_in1} !== {e_issue, e_in0, e_in1}) begin
                failures++;
                $display("FAIL rand_issue cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, unit_issue,
                         unit_in0, unit_in1, e_issue, e_in0, e_in1);
            end
            checks++;
            if ({rsp0_valid, rsp1_valid, (e_rsp0 | e_rsp1) ? rsp_result : 1'b0} !== {e_rsp0, e_rsp1, e_res}) begin
                failures++;
                $display("FAIL rand_rsp cyc=%0d got=%b%b%b exp=%b%b%b", cyc, rsp0_valid, rsp1_valid,
                         rsp_result, e_rsp0, e_rsp1, e_res);
            end
            checks++;
            if ({flush_done, busy} !== {e_fd, e_busy}) begin
                failures++;
                $display("FAIL rand_fd_busy cyc=%0d got=%b%b exp=%b%b", cyc, flush_done, busy, e_fd, e_busy);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        for (int i = 0; i < 2; i++) begin
            req0_valid = 1; req1_valid = 1;
            req0_a = 3'd6; req0_b = 3'd3; req1_a = 3'd2; req1_b = 3'd5;
            sample();
            advance();
        end
        idle_inputs();
        sample();
        advance();
        reset = 1;
        #1;
        checks++;
        if ({unit_issue, unit_in0, unit_in1, rsp0_valid, rsp1_valid, rsp_result, flush_done, busy} !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b/%0d/%0d/%b%b%b/%b/%b exp=all0", unit_issue, unit_in0,
                     unit_in1, rsp0_valid, rsp1_valid, rsp_result, flush_done, busy);
        end
        @(posedge clk);
        #1;
        reset = 0;
        cyc++;
        model_clear();
        unit_result = 0;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) stray++;
            advance();
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_stray_rsp got=%0d exp=0", stray);
        end
        req0_valid = 1; req1_valid = 1;
        sample();
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_grant got=%b%b exp=10", req0_ready, req1_ready);
        end
        advance();
        idle_inputs();
        repeat (6) begin
            sample();
            advance();
        end
    endtask

`ifdef VALIDITY_SCHED_STATS_EN
    task automatic do_flush(output int fd_seen);
        fd_seen = 0;
        flush = 1;
        sample();
        advance();
        flush = 0;
        for (int i = 0; i < 20 && fd_seen == 0; i++) begin
            sample();
            if (flush_done === 1'b1) fd_seen = 1;
            advance();
        end
    endtask

    task automatic test_stats();
        int seen;
        do_flush(seen);
        for (int i = 0; i < 8; i++) begin
            req0_valid = (i < 5); req1_valid = (i >= 5);
            sample();
            advance();
        end
        idle_inputs();
        sample();
        checks++;
        if (grant_cnt0 !== 16'd5 || grant_cnt1 !== 16'd3) begin
            failures++;
            $display("FAIL stats_counts got=%0d/%0d exp=5/3", grant_cnt0, grant_cnt1);
        end
        advance();
        do_flush(seen);
        sample();
        checks++;
        if (seen != 1 || grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
            failures++;
            $display("FAIL stats_clear got=%0d/%0d fd=%0d exp=0/0 fd=1", grant_cnt0, grant_cnt1, seen);
        end
        advance();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; unit_result = 0;
        idle_inputs();
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        model_clear();
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        test_reset();
        test_contention();
        test_single();
        test_truncate();
        test_flush();
        test_random();
        test_reset_mid();
`ifdef VALIDITY_SCHED_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
